// File: rtl/gate_input_debouncer.sv
// rtl/gate_input_debouncer.sv - synchronise, debounce and edge-detect a raw input (optional glitch counter: GATE_DBNC_GLITCH_CNT_EN)
module gate_input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter bit RESET_LEVEL   = 1'b0
`ifdef GATE_DBNC_GLITCH_CNT_EN
  , parameter int GLITCH_W    = 8
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                A_raw,
  output logic                A,
  output logic                rise,
  output logic                fall
`ifdef GATE_DBNC_GLITCH_CNT_EN
  , output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    CHECK_HIGH,
    IDLE_HIGH,
    CHECK_LOW
  } state_t;

  localparam state_t RESET_STATE = RESET_LEVEL ? IDLE_HIGH : IDLE_LOW;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   a_q, a_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], A_raw};
  end

  // A qualification needs STABLE_CYCLES consecutive opposite samples; any reversal drops back to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = CHECK_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          a_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = CHECK_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          a_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      a_q     <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign A    = a_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef GATE_DBNC_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                abort;

  // An abort is a CHECK state seeing the input fall back to the current level.
  always_comb begin
    abort    = ((state_q == CHECK_HIGH) && !s) || ((state_q == CHECK_LOW) && s);
    glitch_d = glitch_q;
    if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_gate_input_debouncer.sv
// tb/tb_gate_input_debouncer.sv - bench for gate_input_debouncer (GATE_DBNC_GLITCH_CNT_EN optional)
`timescale 1ns/1ps
module tb_gate_input_debouncer;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam bit RL     = 1'b0;
`ifdef GATE_DBNC_GLITCH_CNT_EN
  localparam int GW     = 2;
`endif

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic A_raw = 1'b1;
  logic A, rise, fall;
`ifdef GATE_DBNC_GLITCH_CNT_EN
  logic [GW-1:0] glitch_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  gate_input_debouncer #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .RESET_LEVEL  (RL)
`ifdef GATE_DBNC_GLITCH_CNT_EN
    , .GLITCH_W   (GW)
`endif
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .A_raw (A_raw),
    .A     (A),
    .rise  (rise),
    .fall  (fall)
`ifdef GATE_DBNC_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: s is A_raw delayed SYNC edges; A flips once s has differed from A for STABLE samples in a row.
  bit pipe [SYNC];
  bit m_a    = RL;
  bit m_rise = 1'b0;
  bit m_fall = 1'b0;
  int run    = 0;
`ifdef GATE_DBNC_GLITCH_CNT_EN
  int m_glitch = 0;
`endif

  initial begin
    forever begin
      bit s_seen;
      @(posedge clk);
      s_seen = pipe[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = rst ? RL : A_raw;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (rst) begin
        m_a = RL;
        run = 0;
`ifdef GATE_DBNC_GLITCH_CNT_EN
        m_glitch = 0;
`endif
      end else if (s_seen != m_a) begin
        run++;
        if (run == STABLE) begin
          m_a    = s_seen;
          m_rise = s_seen;
          m_fall = !s_seen;
          run    = 0;
        end
      end else begin
`ifdef GATE_DBNC_GLITCH_CNT_EN
        if (run > 0 && m_glitch < (1 << GW) - 1) m_glitch++;
`endif
        run = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("A_model", A, m_a);
        check("rise_model", rise, m_rise);
        check("fall_model", fall, m_fall);
        check("rise_fall_exclusive", rise & fall, 0);
`ifdef GATE_DBNC_GLITCH_CNT_EN
        check("glitch_model", glitch_cnt, m_glitch);
`endif
      end
    end
  end

  initial begin
    // Reset with A_raw high must still give A=0
    rst = 1'b1; A_raw = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_A", A, 0);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
`ifdef GATE_DBNC_GLITCH_CNT_EN
    check("reset_glitch", glitch_cnt, 0);
`endif
    cmp_en = 1'b1;
    rst = 1'b0; A_raw = 1'b0;
    repeat (4) @(negedge clk);

    // Clean rise: A changes at edge 5
    A_raw = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 4) check("rise_A_edge4", A, 0);
      if (k == 5) begin
        check("rise_A_edge5", A, 1);
        check("rise_pulse_edge5", rise, 1);
        check("rise_nofall_edge5", fall, 0);
      end
      if (k == 6) check("rise_pulse_edge6", rise, 0);
    end
    repeat (3) @(negedge clk);

    // Clean fall
    A_raw = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 4) check("fall_A_edge4", A, 1);
      if (k == 5) begin
        check("fall_A_edge5", A, 0);
        check("fall_pulse_edge5", fall, 1);
      end
      if (k == 6) check("fall_pulse_edge6", fall, 0);
    end
    repeat (3) @(negedge clk);

    // Bounce: two high cycles then low
    A_raw = 1'b1;
    repeat (2) @(negedge clk);
    A_raw = 1'b0;
    repeat (8) @(negedge clk);
    check("bounce_A", A, 0);
`ifdef GATE_DBNC_GLITCH_CNT_EN
    check("bounce_glitch", glitch_cnt, 1);
`endif

    // Reset asserted at edge 3 of a qualification
    A_raw = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_A", A, 0);
    check("midrst_rise", rise, 0);
`ifdef GATE_DBNC_GLITCH_CNT_EN
    check("midrst_glitch", glitch_cnt, 0);
`endif
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 4) check("midrst_A_edge4", A, 0);
      if (k == 5) begin
        check("midrst_A_edge5", A, 1);
        check("midrst_rise_edge5", rise, 1);
      end
    end
    @(negedge clk);

    // Back to low, then five single-cycle pulses
    A_raw = 1'b0;
    repeat (8) @(negedge clk);
    check("sat_pre_A", A, 0);
    for (int p = 0; p < 5; p++) begin
      A_raw = 1'b1;
      @(negedge clk);
      A_raw = 1'b0;
      repeat (5) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("sat_A", A, 0);
`ifdef GATE_DBNC_GLITCH_CNT_EN
    check("sat_glitch", glitch_cnt, 3);
`endif

    // Randomised segments with occasional resets
    for (int seg = 0; seg < 500; seg++) begin
      int len;
      len   = $urandom_range(1, 8);
      A_raw = 1'($urandom_range(0, 1));
      for (int c = 0; c < len; c++) begin
        rst = ($urandom_range(0, 99) == 0);
        @(negedge clk);
      end
      rst = 1'b0;
    end
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
